// File: rtl/fdd_pkg.sv
// fdd_pkg: shared types and constants for the floppy drive motor controller.
// Holds the per-drive motor state encoding and the counter widths used by
// fdd_motor_fsm and fdd_motor_ctrl.
package fdd_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        SPINUP  = 2'd1,
        RUN     = 2'd2,
        RUNDOWN = 2'd3
    } motor_state_t;

    // One revolution at 300 RPM lasts 200 ms.
    localparam int ROT_MS = 200;
    // Millisecond down-counter width, covers SPINUP_MS / HOLD_MS up to 4095.
    localparam int CNT_W  = 12;
    // Rotation position width, covers 0..ROT_MS-1.
    localparam int ROT_W  = 8;

endpackage

// File: rtl/fdd_motor_fsm.sv
// fdd_motor_fsm: motor state machine for a single floppy drive.
// Tracks spin-up, running and (optionally) run-on after the request drops,
// and keeps the rotation position used for index pulse generation.
// Build option: define FDD_MOTOR_HOLD_EN to enable the RUNDOWN run-on state;
// without it a dropped request in RUN stops the motor on the next cycle.
module fdd_motor_fsm
    import fdd_pkg::*;
#(
    parameter int SPINUP_MS = 250,
    parameter int HOLD_MS   = 2000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motor_req,
    input  logic             ms_tick,
    output logic             motor_run,
    output logic [ROT_W-1:0] rot
);

`ifdef FDD_MOTOR_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SPINUP_LOAD = CNT_W'(SPINUP_MS);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [ROT_W-1:0] ROT_LAST    = ROT_W'(ROT_MS - 1);
    localparam logic [ROT_W-1:0] ROT_ONE     = ROT_W'(1);

    motor_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [ROT_W-1:0] rot_next;

    // Next rotation position, wrapping once per revolution.
    always_comb begin
        rot_next = (rot == ROT_LAST) ? '0 : rot + ROT_ONE;
    end

    // Motor FSM; request changes win over a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= OFF;
            cnt       <= '0;
            rot       <= '0;
            motor_run <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (motor_req) begin
                        state <= SPINUP;
                        cnt   <= SPINUP_LOAD;
                    end
                end
                SPINUP: begin
                    if (!motor_req) begin
                        state <= OFF;
                        cnt   <= '0;
                    end else if (ms_tick) begin
                        if (cnt == CNT_ONE) begin
                            state     <= RUN;
                            cnt       <= '0;
                            rot       <= '0;
                            motor_run <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                RUN: begin
                    if (!motor_req) begin
                        if (HOLD_EN) begin
                            state <= RUNDOWN;
                            cnt   <= HOLD_LOAD;
                        end else begin
                            state     <= OFF;
                            motor_run <= 1'b0;
                        end
                    end else if (ms_tick) begin
                        rot <= rot_next;
                    end
                end
                RUNDOWN: begin
                    if (motor_req) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (ms_tick) begin
                        rot <= rot_next;
                        if (cnt == CNT_ONE) begin
                            state     <= OFF;
                            cnt       <= '0;
                            motor_run <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state     <= OFF;
                    motor_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fdd_motor_ctrl.sv
// fdd_motor_ctrl: two-drive floppy motor controller.
// Generates the shared 1 ms tick, runs one motor FSM per drive and produces
// the active-low index pulse for the selected drive.
// Build option: FDD_MOTOR_HOLD_EN enables motor run-on (RUNDOWN) in each FSM.
module fdd_motor_ctrl
    import fdd_pkg::*;
#(
    parameter int CLK_KHZ   = 21477,
    parameter int SPINUP_MS = 250,
    parameter int HOLD_MS   = 2000,
    parameter int INDEX_MS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] motor_req,
    input  logic [1:0] disk_present,
    input  logic       USEL,
    output logic [1:0] motor_run,
    output logic       INDEXn,
    output logic       ms_tick
);

    localparam int               PRE_W      = (CLK_KHZ > 2) ? $clog2(CLK_KHZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_KHZ - 1);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);
    localparam logic [ROT_W-1:0] INDEX_LIM  = ROT_W'(INDEX_MS);

    logic [PRE_W-1:0] pre_cnt;
    logic [ROT_W-1:0] rot0;
    logic [ROT_W-1:0] rot1;
    logic [ROT_W-1:0] rot_sel;

    // Free-running prescaler; the tick is registered so it is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            ms_tick <= 1'b0;
        end else begin
            ms_tick <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_ONE;
        end
    end

    fdd_motor_fsm #(
        .SPINUP_MS (SPINUP_MS),
        .HOLD_MS   (HOLD_MS)
    ) u_drive0 (
        .clk       (clk),
        .reset     (reset),
        .motor_req (motor_req[0]),
        .ms_tick   (ms_tick),
        .motor_run (motor_run[0]),
        .rot       (rot0)
    );

    fdd_motor_fsm #(
        .SPINUP_MS (SPINUP_MS),
        .HOLD_MS   (HOLD_MS)
    ) u_drive1 (
        .clk       (clk),
        .reset     (reset),
        .motor_req (motor_req[1]),
        .ms_tick   (ms_tick),
        .motor_run (motor_run[1]),
        .rot       (rot1)
    );

    // Index pulse of the selected drive, low during the first INDEX_MS of a turn.
    always_comb begin
        rot_sel = USEL ? rot1 : rot0;
        INDEXn  = !(motor_run[USEL] && disk_present[USEL] && (rot_sel < INDEX_LIM));
    end

endmodule

// File: doc/fdd_motor_ctrl.md
FDD_MOTOR_CTRL -- requirements
Module: fdd_motor_ctrl

Interface
REQ-001 SHALL have parameter CLK_KHZ, default 21477: clk frequency in kHz; sets the 1 ms tick prescaler; must be >=2.
REQ-002 SHALL have parameter SPINUP_MS, default 250: motor spin-up delay in ms; range 1..4095.
REQ-003 SHALL have parameter HOLD_MS, default 2000: motor run-on time after the request drops, in ms; range 1..4095.
REQ-004 SHALL have parameter INDEX_MS, default 4: index pulse width in ms; range 1..199.
REQ-005 SHALL have port clk, input, 1 bit: single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port motor_req, input, 2 bits: per-drive motor-on request from the FDC latch.
REQ-008 SHALL have port disk_present, input, 2 bits: per-drive image mounted and valid.
REQ-009 SHALL have port USEL, input, 1 bit: selected drive.
REQ-010 SHALL have port motor_run, output, 2 bits: per-drive motor at speed; feeds drive-ready logic.
REQ-011 SHALL have port INDEXn, output, 1 bit: active-low index pulse of the selected drive.
REQ-012 SHALL have port ms_tick, output, 1 bit: one-cycle pulse each millisecond.

Function
REQ-013 SHALL generate ms_tick from a free-running prescaler that pulses once every CLK_KHZ clk cycles; the prescaler is never reloaded by drive activity.
REQ-014 SHALL run one independent FSM per drive with states OFF, SPINUP, RUN and RUNDOWN.
REQ-015 In OFF with motor_req[i]=1, the FSM SHALL go to SPINUP next cycle and load cnt[i]=SPINUP_MS.
REQ-016 In SPINUP, each ms_tick SHALL decrement cnt[i]; a tick when cnt[i]==1 SHALL go to RUN; motor_req[i]=0 SHALL go to OFF.
REQ-017 In RUN with motor_req[i]=0, the FSM SHALL go to RUNDOWN and load cnt[i]=HOLD_MS.
REQ-018 In RUNDOWN, motor_req[i]=1 SHALL return to RUN without a new spin-up; otherwise a tick when cnt[i]==1 SHALL go to OFF.
REQ-019 When a motor_req change and ms_tick coincide, the request transition SHALL take priority and the tick SHALL be ignored for that drive.
REQ-020 motor_run[i] SHALL be registered and equal 1 exactly while the FSM is in RUN or RUNDOWN.
REQ-021 Each drive SHALL have a rotation counter rot[i] (0..199; 300 RPM) that clears on entry to RUN from SPINUP, increments on ms_tick while motor_run[i]=1, wraps 199->0, and holds otherwise.
REQ-022 INDEXn SHALL be low when motor_run[USEL]=1, disk_present[USEL]=1 and rot[USEL]<INDEX_MS; otherwise high. Decode is combinational from registers and inputs.
REQ-023 Changing USEL SHALL switch INDEXn source in the same cycle without disturbing either FSM.
REQ-024 A disk_present drop SHALL only gate INDEXn; motor state SHALL be unaffected.

Reset
REQ-025 Asserting reset SHALL, asynchronously and including mid-spin-up or mid-rundown, force both FSMs to OFF, cnt and rot to 0, and the prescaler to 0.
REQ-026 During reset, outputs SHALL be motor_run=2'b00, INDEXn=1 and ms_tick=0; the first ms_tick SHALL occur CLK_KHZ cycles after reset deasserts.

Configuration
REQ-027 Macro FDD_MOTOR_HOLD_EN: when defined, RUNDOWN SHALL behave as in REQ-017 and REQ-018.
REQ-028 When FDD_MOTOR_HOLD_EN is undefined, RUN with motor_req[i]=0 SHALL go directly to OFF, RUNDOWN SHALL be unreachable, and HOLD_MS SHALL be ignored.

Structure
REQ-029 Package fdd_pkg SHALL hold the motor_state_t enum (OFF, SPINUP, RUN, RUNDOWN) and the constants ROT_MS=200 and CNT_W=12.
REQ-030 A sub-module fdd_motor_fsm SHALL contain one drive's FSM, cnt and rot; fdd_motor_ctrl SHALL instantiate it twice, driven by the shared ms_tick, and SHALL contain the prescaler and the INDEXn mux.

Verification (CLK_KHZ=4, SPINUP_MS=3, HOLD_MS=5, INDEX_MS=2)
REQ-031 Spin-up: after reset, set motor_req=01 -> motor_run[0] rises on the 3rd ms_tick after SPINUP entry; motor_run[1] stays 0.
REQ-032 Abort: drop motor_req[0] after 1 tick of SPINUP -> OFF next cycle; motor_run stays 0; a re-request restarts the full 3-tick spin-up.
REQ-033 Hold (macro defined): drop the request in RUN -> motor_run stays 1 for 5 ticks then falls; a re-request at tick 3 keeps motor_run=1 with no spin-up.
REQ-034 Index: USEL=0, disk_present=01, drive 0 running -> INDEXn low for 2 ticks every 200 ticks; disk_present=00 -> INDEXn stays high; USEL=1 with drive 1 off -> INDEXn high.
REQ-035 Reset mid-RUNDOWN -> motor_run=00 and INDEXn=1 immediately (asynchronous); without the macro, dropping the request in RUN -> motor_run=0 on the next cycle.
